aes_resp_monitor: RTL and testbench

//  On-chip response side of the AES test flow. Watches the core's ld/done handshake, compacts every

---
 rtl/aes_test_pkg.sv | 32 +++
 rtl/aes_misr128.sv | 32 +++
 rtl/aes_resp_monitor.sv | 154 +++++++++++++++
 tb/tb_aes_resp_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_test_pkg
// Description : Shared types, constants and the MISR step function for the
//               AES on-chip BIST blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_test_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    FINAL     = 2'd2
  } resp_state_t;

  // Feedback taps for x^128 + x^7 + x^2 + x + 1
  localparam logic [127:0] MISR_POLY = 128'h87;

  // One MISR compaction step: shift left, fold the carried-out MSB back
  // through the polynomial, then XOR in the new data word.
  function automatic logic [127:0] misr_step(input logic [127:0] sig,
                                             input logic [127:0] data);
    logic [127:0] w_shift;
    w_shift = {sig[126:0], 1'b0};
    if (sig[127]) begin
      w_shift = w_shift ^ MISR_POLY;
    end
    return w_shift ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_misr128.sv
`default_nettype none
// ============================================================================
// Module      : aes_misr128
// Description : 128-bit multiple-input signature register. Compacts one data
//               word per enabled clock.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_misr128
  import aes_test_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] data,
  output logic [127:0] sig
);

  logic [127:0] r_sig;

  // Signature register: advances one MISR step whenever a word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= misr_step(r_sig, data);
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/aes_resp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : aes_resp_monitor
// Description : Response side of the AES BIST loop. Tracks the ld/done
//               handshake, compacts each text_out into a MISR signature,
//               counts vectors and flags hung encryptions.
//               Optional macro AES_RESP_MONITOR_GOLDEN_CHECK_EN enables the
//               registered golden-signature pass flag.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_resp_monitor
  import aes_test_pkg::*;
#(
  parameter int           NUM_VECTORS = 16,
  parameter int           TIMEOUT     = 30,
  parameter logic [127:0] GOLDEN_SIG  = 128'h0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ld,
  input  logic                               done,
  input  logic [127:0]                       text_out,
  output logic [127:0]                       signature,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
  output logic                               sig_valid,
  output logic                               timeout_err,
  output logic                               pass
);

  localparam int CNT_W = $clog2(NUM_VECTORS + 1);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_num_vec  = CNT_W'(NUM_VECTORS);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);

  resp_state_t      r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [CNT_W-1:0] r_vec_count, w_count_nxt;
  logic             r_sig_valid, w_sig_valid_nxt;
  logic             r_timeout_err, w_timeout_nxt;
  logic             w_capture;
  logic             w_final_entry;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, timer, counter and flag logic for the ld/done handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_count_nxt     = r_vec_count;
    w_sig_valid_nxt = r_sig_valid;
    w_timeout_nxt   = r_timeout_err;
    w_capture       = 1'b0;
    w_final_entry   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld) begin
          w_state_nxt = WAIT_DONE;
          w_timer_nxt = '0;
        end
      end
      WAIT_DONE: begin
        w_timer_nxt = r_timer + 1'b1;
        if (done) begin
          w_capture = 1'b1;
          if (r_vec_count != c_num_vec) begin
            w_count_nxt = r_vec_count + 1'b1;
          end
          if (w_count_nxt == c_num_vec) begin
            w_state_nxt     = FINAL;
            w_sig_valid_nxt = 1'b1;
            w_final_entry   = 1'b1;
          end else if (ld) begin
            // Back-to-back vector: the new ld starts a fresh wait window.
            w_timer_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (ld) begin
          // Re-issued load without completion restarts the wait window.
          w_timer_nxt = '0;
        end else if (r_timer == c_tmr_last) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      FINAL: begin
        // Terminal until reset; everything frozen.
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Timer, vector counter and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer       <= '0;
      r_vec_count   <= '0;
      r_sig_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timer       <= w_timer_nxt;
      r_vec_count   <= w_count_nxt;
      r_sig_valid   <= w_sig_valid_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  aes_misr128 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_capture),
    .data  (text_out),
    .sig   (signature)
  );

  assign vec_count   = r_vec_count;
  assign sig_valid   = r_sig_valid;
  assign timeout_err = r_timeout_err;

`ifdef AES_RESP_MONITOR_GOLDEN_CHECK_EN
  logic         r_pass;
  logic [127:0] w_sig_nxt;

  // The comparison is made against the value the MISR is about to take, so
  // the verdict lands on the same edge that finalises the signature.
  assign w_sig_nxt = misr_step(signature, text_out);

  // Sticky verdict, evaluated once on entry to FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (w_final_entry && !w_timeout_nxt && (w_sig_nxt == GOLDEN_SIG)) begin
      r_pass <= 1'b1;
    end
  end

  assign pass = r_pass;
`else
  logic w_unused_golden;
  assign w_unused_golden = ^GOLDEN_SIG;
  assign pass = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_resp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_resp_monitor
// Description : Scoreboard bench for aes_resp_monitor (NUM_VECTORS=4,
//               TIMEOUT=30). Two instances share stimulus: one with a golden
//               signature that matches the known run, one off by a single bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_resp_monitor;

  localparam int NV = 4;
  localparam int TO = 30;
  localparam int CW = $clog2(NV + 1);

  function automatic logic [127:0] f_data(input int i);
    case (i)
      0:       return 128'h0123456789abcdeffedcba9876543210;
      1:       return 128'h80000000000000000000000000000001;
      2:       return 128'hdeadbeefcafebabe0badf00d12345678;
      default: return 128'h00000000000000000000000000000001;
    endcase
  endfunction

  function automatic logic [127:0] f_step(input logic [127:0] s, input logic [127:0] d);
    logic [127:0] r;
    r = {s[126:0], 1'b0} ^ d;
    if (s[127]) r = r ^ 128'h87;
    return r;
  endfunction

  function automatic logic [127:0] f_golden();
    logic [127:0] s;
    s = '0;
    for (int i = 0; i < NV; i++) s = f_step(s, f_data(i));
    return s;
  endfunction

  localparam logic [127:0] c_gold     = f_golden();
  localparam logic [127:0] c_gold_bad = c_gold ^ 128'h1;
`ifdef AES_RESP_MONITOR_GOLDEN_CHECK_EN
  localparam logic c_pass_exp = 1'b1;
`else
  localparam logic c_pass_exp = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          ld;
  logic          done;
  logic [127:0]  text_out;
  logic [127:0]  sig_a;
  logic [CW-1:0] cnt_a;
  logic          sv_a;
  logic          to_a;
  logic          pass_a;
  logic [127:0]  sig_unused_b;
  logic [CW-1:0] cnt_unused_b;
  logic          sv_unused_b;
  logic          to_unused_b;
  logic          pass_b;

  aes_resp_monitor #(.NUM_VECTORS(NV), .TIMEOUT(TO), .GOLDEN_SIG(c_gold)) u_dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .done(done), .text_out(text_out),
    .signature(sig_a), .vec_count(cnt_a), .sig_valid(sv_a),
    .timeout_err(to_a), .pass(pass_a)
  );

  aes_resp_monitor #(.NUM_VECTORS(NV), .TIMEOUT(TO), .GOLDEN_SIG(c_gold_bad)) u_dut_bad (
    .clk(clk), .rst_n(rst_n), .ld(ld), .done(done), .text_out(text_out),
    .signature(sig_unused_b), .vec_count(cnt_unused_b), .sig_valid(sv_unused_b),
    .timeout_err(to_unused_b), .pass(pass_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0]  sig;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q_exp[$];
  logic [127:0]  m_sig;
  logic [CW-1:0] m_cnt;
  int            n_checks;
  int            n_errors;

  task automatic t_check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic t_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic t_reset();
    rst_n = 1'b0;
    ld    = 1'b0;
    done  = 1'b0;
    t_cycles(2);
    rst_n = 1'b1;
    m_sig = '0;
    m_cnt = '0;
    t_cycles(1);
  endtask

  task automatic t_ld();
    ld = 1'b1;
    t_cycles(1);
    ld = 1'b0;
  endtask

  // Drive one done pulse (optionally with ld), push the model's expectation,
  // then pop it once the DUT has had its edge.
  task automatic t_done(input string tag, input logic [127:0] d, input logic with_ld);
    exp_t e;
    done     = 1'b1;
    ld       = with_ld;
    text_out = d;
    if (m_cnt != CW'(NV)) begin
      m_sig = f_step(m_sig, d);
      m_cnt = m_cnt + 1'b1;
    end
    q_exp.push_back('{sig: m_sig, cnt: m_cnt});
    t_cycles(1);
    done = 1'b0;
    ld   = 1'b0;
    if (q_exp.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q_exp.pop_front();
      t_check({tag, "_sig"}, sig_a, e.sig);
      t_check({tag, "_cnt"}, 128'(cnt_a), 128'(e.cnt));
      t_check({tag, "_valid"}, 128'(sv_a), 128'(m_cnt == CW'(NV)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    text_out = '0;
    t_reset();

    // Reset values
    t_check("rst_sig",   sig_a, 128'h0);
    t_check("rst_cnt",   128'(cnt_a), 128'h0);
    t_check("rst_valid", 128'(sv_a), 128'h0);
    t_check("rst_to",    128'(to_a), 128'h0);
    t_check("rst_pass",  128'(pass_a), 128'h0);

    // Single vector, done 21 cycles after ld
    t_ld();
    t_cycles(20);
    t_done("vec1", 128'h1, 1'b0);
    t_check("vec1_const", sig_a, 128'h1);

    // Second vector
    t_ld();
    t_cycles(4);
    t_done("vec2", 128'h1, 1'b0);
    t_check("vec2_const", sig_a, 128'h3);

    // Asynchronous reset in the middle of a wait
    t_ld();
    t_cycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    t_check("arst_sig",   sig_a, 128'h0);
    t_check("arst_cnt",   128'(cnt_a), 128'h0);
    t_check("arst_valid", 128'(sv_a), 128'h0);
    t_check("arst_to",    128'(to_a), 128'h0);
    t_cycles(1);
    rst_n = 1'b1;
    m_sig = '0;
    m_cnt = '0;
    t_cycles(1);
    // Back in IDLE: an unsolicited done is ignored
    done     = 1'b1;
    text_out = 128'h5;
    t_cycles(1);
    done = 1'b0;
    t_check("idle_done_sig", sig_a, 128'h0);
    t_check("idle_done_cnt", 128'(cnt_a), 128'h0);

    // MSB feedback case
    t_ld();
    t_cycles(2);
    t_done("msb_load", 128'h80000000000000000000000000000000, 1'b0);
    t_ld();
    t_cycles(2);
    t_done("msb_fold", 128'h0, 1'b0);
    t_check("msb_const", sig_a, 128'h87);

    // Timeout: one good vector, then an ld that never completes
    t_reset();
    t_ld();
    t_cycles(2);
    t_done("pre_to", 128'h7, 1'b0);
    t_ld();
    t_cycles(29);
    t_check("to_edge29", 128'(to_a), 128'h0);
    t_cycles(1);
    t_check("to_edge30", 128'(to_a), 128'h1);
    t_check("to_cnt",    128'(cnt_a), 128'(m_cnt));
    done     = 1'b1;
    text_out = 128'h9;
    t_cycles(1);
    done = 1'b0;
    t_check("to_idle_sig", sig_a, m_sig);
    t_check("to_idle_cnt", 128'(cnt_a), 128'(m_cnt));
    t_check("to_sticky",   128'(to_a), 128'h1);

    // done+ld together, then ld-only restart, then a late done
    t_reset();
    t_ld();
    t_cycles(3);
    t_done("dl_cap", 128'h1234, 1'b1);
    t_cycles(9);
    t_ld();
    t_check("restart_sig", sig_a, m_sig);
    t_check("restart_cnt", 128'(cnt_a), 128'(m_cnt));
    t_cycles(28);
    t_check("restart_to", 128'(to_a), 128'h0);
    t_done("late_done", 128'h5678, 1'b0);
    t_check("late_to", 128'(to_a), 128'h0);

    // Full run of NUM_VECTORS with known data
    t_reset();
    for (int i = 0; i < NV; i++) begin
      t_ld();
      t_cycles(2);
      t_done("run", f_data(i), 1'b0);
    end
    t_check("final_sig",  sig_a, c_gold);
    t_check("final_cnt",  128'(cnt_a), 128'(NV));
    t_check("pass_match", 128'(pass_a), 128'(c_pass_exp));
    t_check("pass_bad",   128'(pass_b), 128'h0);
    // FINAL ignores further traffic
    t_ld();
    t_cycles(2);
    t_done("frozen", 128'hffff, 1'b1);
    t_check("frozen_gold", sig_a, c_gold);
    t_check("frozen_pass", 128'(pass_a), 128'(c_pass_exp));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
